// File: rtl/int_to_float_converter_if.sv
// Operand/result bundle between an integer producer and int_to_float_converter.
// Carries the operand handshake plus the packed float result and its status code.
interface int_to_float_converter_if #(
    parameter int unsigned INT_W = 32
);
    logic [INT_W-1:0] a;
    logic             arg_vld;
    logic             arg_rdy;
    logic [31:0]      result;
    logic [1:0]       res_state;

    modport master (
        output a,
        output arg_vld,
        input  arg_rdy,
        input  result,
        input  res_state
    );

    modport slave (
        input  a,
        input  arg_vld,
        output arg_rdy,
        output result,
        output res_state
    );
endinterface

// File: rtl/int_to_float_converter.sv
// Serial signed-integer to IEEE-754 single converter, normalising one bit per cycle.
// Define ITOF_RNE_EN for round-to-nearest-even; otherwise the mantissa is truncated.
module int_to_float_converter #(
    parameter int unsigned INT_W = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    int_to_float_converter_if.slave   bus
);

    localparam int unsigned FW      = INT_W + 23;
    localparam logic [7:0]  EXP_TOP = 8'(127 + INT_W - 1);

    typedef enum logic [1:0] {
        StIdle,
        StNorm,
        StRound,
        StDone
    } state_e;

    state_e           state_q, state_d;
    logic [INT_W-1:0] mag_q, mag_d;
    logic [4:0]       shcnt_q, shcnt_d;
    logic             sign_q, sign_d;
    logic             inexact_q, inexact_d;
    logic [31:0]      result_q, result_d;

    logic             accept;
    logic [INT_W-1:0] a_abs;
    logic [FW-1:0]    frac;
    logic [22:0]      mant_trunc;
    logic             guard;
    logic             sticky;
    logic             round_up;
    logic [23:0]      mant_sum;
    logic [7:0]       exp_base;
    logic [7:0]       exp_fin;

    assign bus.arg_rdy = (state_q == StIdle) || (state_q == StDone);
    assign accept      = bus.arg_vld && bus.arg_rdy;

    // Unsigned negation maps the most negative input onto 2^(INT_W-1) without overflow.
    assign a_abs = bus.a[INT_W-1] ? (~bus.a + INT_W'(1)) : bus.a;

    // Bits below the hidden one, zero-padded so G and the mantissa exist for any INT_W.
    assign frac       = {mag_q[INT_W-2:0], 24'b0};
    assign mant_trunc = frac[FW-1 -: 23];
    assign guard      = frac[FW-24];
    assign sticky     = |frac[FW-25:0];

`ifdef ITOF_RNE_EN
    assign round_up = guard & (sticky | mant_trunc[0]);
`else
    assign round_up = 1'b0;
`endif

    // A carry out leaves mant_sum[22:0] at zero, so only the exponent needs bumping.
    assign mant_sum = {1'b0, mant_trunc} + {23'b0, round_up};
    assign exp_base = EXP_TOP - {3'b0, shcnt_q};
    assign exp_fin  = exp_base + {7'b0, mant_sum[23]};

    always_comb begin
        state_d   = state_q;
        mag_d     = mag_q;
        shcnt_d   = shcnt_q;
        sign_d    = sign_q;
        inexact_d = inexact_q;
        result_d  = result_q;

        unique case (state_q)
            StIdle, StDone: begin
                state_d = StIdle;
                if (accept) begin
                    sign_d    = bus.a[INT_W-1];
                    mag_d     = a_abs;
                    shcnt_d   = 5'd0;
                    inexact_d = 1'b0;
                    if (bus.a == '0) begin
                        result_d = 32'h0;
                        state_d  = StDone;
                    end else begin
                        state_d  = StNorm;
                    end
                end
            end
            StNorm: begin
                if (!mag_q[INT_W-1]) begin
                    mag_d   = mag_q << 1;
                    shcnt_d = shcnt_q + 5'd1;
                end else begin
                    state_d = StRound;
                end
            end
            StRound: begin
                result_d  = {sign_q, exp_fin, mant_sum[22:0]};
                inexact_d = guard | sticky;
                state_d   = StDone;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        bus.res_state = 2'b00;
        unique case (state_q)
            StIdle:          bus.res_state = 2'b00;
            StNorm, StRound: bus.res_state = 2'b11;
            StDone:          bus.res_state = inexact_q ? 2'b10 : 2'b01;
            default:         bus.res_state = 2'b00;
        endcase
    end

    assign bus.result = result_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            mag_q     <= '0;
            shcnt_q   <= 5'd0;
            sign_q    <= 1'b0;
            inexact_q <= 1'b0;
            result_q  <= 32'h0;
        end else begin
            state_q   <= state_d;
            mag_q     <= mag_d;
            shcnt_q   <= shcnt_d;
            sign_q    <= sign_d;
            inexact_q <= inexact_d;
            result_q  <= result_d;
        end
    end

endmodule

// File: doc/int_to_float_converter.md
# int_to_float_converter

Iterative signed-integer to IEEE-754 single-precision converter. It produces `float_point_num` operands (sign/exp/mant) for `floating_point_adder` and the rest of the FPU datapath. It is the encoding end of the float interface. Handshake and status encoding match the adder: `arg_vld` in, `result` plus `res_state` out. Normalisation is serial, one bit per cycle, to keep area low.

## Interface
- `INT_W`, 32: input integer width, legal range 16..32; the input is two's complement.
- `clk` in 1: single clock, all state updates on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `a` in INT_W: signed integer operand, sampled when `arg_vld && arg_rdy`.
- `arg_vld` in 1: operand valid.
- `arg_rdy` out 1: converter can accept an operand this cycle.
- `result` out 32 (`float_point_num`): converted value {sign, exp[7:0], mant[22:0]}.
- `res_state` out 2: status.
  - 2'b00: no new result.
  - 2'b01: result valid, exact.
  - 2'b10: result valid, inexact (rounded or truncated).
  - 2'b11: busy.

## Operation
- FSM states: IDLE, NORM, ROUND, DONE.
- `arg_rdy` = 1 in IDLE and DONE, 0 in NORM and ROUND.
- **Accept** (`arg_vld && arg_rdy`):
  - Register `sign = a[INT_W-1]` and `mag = |a|` as an unsigned INT_W value. The most negative value maps to 2^(INT_W-1) with no overflow.
  - Clear `shcnt`.
  - If `a == 0`, go to DONE with `result = 32'h0` and status 01. Otherwise go to NORM.
- **NORM**:
  - If `mag[INT_W-1] == 0`, shift `mag` left by 1 and increment `shcnt` (5 bits).
  - Otherwise go to ROUND.
- **ROUND**:
  - Exponent: `exp = 127 + (INT_W-1) - shcnt`.
  - Take `mant = mag[INT_W-2 -: 23]`, zero-filled on the right when INT_W-1 < 23.
  - Guard bit G is the next bit below `mant`; sticky S is the OR of all remaining lower bits.
  - Rounding per Configuration.
  - If rounding carries out of `mant`: set `mant = 0` and `exp = exp + 1`.
  - Inexact = G | S.
  - Register `result`, go to DONE.
- **DONE**:
  - `res_state` = 01 or 10 for exactly one cycle.
  - Next state:
    - New accept this cycle: NORM (or DONE for a zero operand).
    - Otherwise: IDLE.
- **IDLE / busy**: `result` holds its last value. `res_state` = 00 in IDLE and 11 in NORM/ROUND.
- `arg_vld` while `arg_rdy = 0` is ignored; the operand is dropped and no error is flagged.
- Reset mid-conversion aborts the operation. After deassertion the block is in IDLE and accepts on the next valid.

## Timing
- Reset values: state IDLE, `result` = 32'h0, `res_state` = 2'b00, `arg_rdy` = 1.
- Latency, counted in rising edges from the accept edge to `res_state` valid:
  - Non-zero operand: 3 + k, where k = number of leading zeros of `mag`. Maximum 3 + (INT_W-1), i.e. 34 for `a = 1` at INT_W = 32.
  - Zero operand: 1.
- Throughput is one conversion per (latency) cycles. DONE overlaps with the next accept, so there is no dead cycle.
- The output is a single-cycle pulse. The consumer samples `result` when `res_state[1] ^ res_state[0]`.

## Configuration
- `ITOF_RNE_EN` defined: round-to-nearest-even. Round up iff G & (S | mant[0]).
- Not defined: truncate toward zero. No carry is possible.
- In both modes `res_state` = 10 whenever G | S.

## Test plan
- `a = 1` → `result` = 32'h3F800000, status 01, after exactly 34 edges. `arg_rdy` is low for 33 cycles.
- `a = -5` → 32'hC0A00000, status 01. `a = 32'h80000000` → 32'hCF000000, status 01.
- `a = 0` → 32'h00000000, status 01, one edge after accept. A back-to-back `a = 2` accepted in that DONE cycle → 32'h40000000.
- `a = 32'h7FFFFFFF`:
  - With `ITOF_RNE_EN`: 32'h4F000000, status 10 (mantissa carry, exponent increment).
  - Without: 32'h4EFFFFFF, status 10.
- `a = 16777217` (2^24+1) with `ITOF_RNE_EN` → tie rounds to even, 32'h4B800000, status 10. `a = 16777219` → 32'h4B800002, status 10.
- Reset and busy behaviour:
  - Assert `rst` asynchronously during NORM → outputs return to reset values immediately.
  - `arg_vld` pulsed with `a = 7` while busy → ignored; the in-flight result is unaffected.
